sram_access_ctrl: RTL and testbench

Upstream bus master for the board's asynchronous 16-bit SRAM. It turns single-word read/write requests from the CPU memory stage (MAR/MDR path) into correctly sequenced active-low SRAM strobes and owns the bidirectional data bus. Its SRAM-side ports connect pin-for-pin to the SRAM, or to the simulation memory model in testbenches.

---
 rtl/sram_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
//
// Bus master for the board's asynchronous 16-bit SRAM. It accepts one
// single-word read or write request at a time from the CPU memory stage and
// turns it into a sequence of active-low SRAM strobes. It also owns the
// bidirectional data bus.
//
// Every strobe, the data-bus enable, ADDR, RdData and Done are registered.
// Each one is decoded from the *next* state, so it changes exactly on the
// clock edge where the state changes. This keeps the outputs glitch-free at
// the SRAM pins.
//
// Parameters
//   WaitStates : extra cycles added to the read-access phase and to the
//                write-pulse phase (0..7).
//
// Ports
//   Clk      in    system clock; all state changes on the rising edge
//   Reset    in    synchronous, active-high
//   Req      in    request strobe; sampled only while idle
//   WrEn     in    1 = write, 0 = read; sampled with Req
//   Addr     in    16-bit word address; sampled with Req
//   WrData   in    write data; sampled with Req
//   ByteEn   in    [1] = upper byte, [0] = lower byte; sampled with Req
//   RdData   out   read result; valid from the read's Done cycle and held
//                  until the next read completes
//   Done     out   one-cycle completion pulse
//   Busy     out   high while an access is in progress
//   CE_N     out   SRAM chip enable (active low)
//   OE_N     out   SRAM output enable (active low)
//   WE_N     out   SRAM write enable (active low)
//   LB_N     out   SRAM lower-byte enable (active low)
//   UB_N     out   SRAM upper-byte enable (active low)
//   ADDR     out   SRAM address, {4'b0, latched Addr}
//   DQ       inout SRAM data bus
// ---------------------------------------------------------------------------
module sram_access_ctrl #(
    parameter int unsigned WaitStates = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WrEn,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    input  logic [1:0]  ByteEn,
    output logic [15:0] RdData,
    output logic        Done,
    output logic        Busy,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        LB_N,
    output logic        UB_N,
    output logic [19:0] ADDR,
    inout  wire  [15:0] DQ
);

    // The wait counter is 3 bits wide, so WaitStates is reduced to that width.
    localparam logic [2:0] wait_load = 3'(WaitStates);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  wait_cnt;
    logic [2:0]  wait_cnt_next;

    // Request fields that must survive after Req is dropped. The address is
    // not listed here because it is held directly in the ADDR register.
    logic [15:0] lat_data;
    logic [1:0]  lat_be;

    logic        accept;
    logic        capture;
    logic        done_next;
    logic [1:0]  be_next;
    logic        ce_n_next;
    logic        oe_n_next;
    logic        we_n_next;
    logic        lb_n_next;
    logic        ub_n_next;
    logic        dq_drive;
    logic        dq_drive_next;

    // Next-state logic and the wait counter.
    // The counter is loaded on entry to RD or WPULSE and counts down to 0.
    // The phase ends in the cycle where the counter reads 0, so each of those
    // phases lasts WaitStates+1 cycles.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        capture       = 1'b0;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (Req) begin
                    accept = 1'b1;
                    if (WrEn) begin
                        state_next = WSETUP;
                    end else begin
                        state_next    = RD;
                        wait_cnt_next = wait_load;
                    end
                end
            end

            RD: begin
                if (wait_cnt == 3'd0) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 3'd1;
                end
            end

            WSETUP: begin
                state_next    = WPULSE;
                wait_cnt_next = wait_load;
            end

            WPULSE: begin
                if (wait_cnt == 3'd0) begin
                    state_next = WHOLD;
                end else begin
                    wait_cnt_next = wait_cnt - 3'd1;
                end
            end

            WHOLD: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobe decode for the coming cycle.
    // On the accepting edge the byte lanes come straight from the request
    // inputs, because the latch has not been loaded yet. After that they come
    // from the latch, so ByteEn can change freely while the access runs.
    // The data bus is driven only in the three write states, and OE_N is
    // high in all of them. This means the controller and the SRAM can never
    // drive DQ at the same time.
    always_comb begin
        be_next       = accept ? ByteEn : lat_be;
        ce_n_next     = (state_next == IDLE);
        oe_n_next     = (state_next != RD);
        we_n_next     = (state_next != WPULSE);
        lb_n_next     = (state_next == IDLE) | ~be_next[0];
        ub_n_next     = (state_next == IDLE) | ~be_next[1];
        dq_drive_next = (state_next == WSETUP) ||
                        (state_next == WPULSE) ||
                        (state_next == WHOLD);
    end

    // State, counter, request latch and registered outputs.
    // When Reset is asserted in the middle of an access, the access is
    // abandoned: the bus is released and no Done is produced.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            lat_data <= 16'h0000;
            lat_be   <= 2'b00;
            ADDR     <= 20'h00000;
            RdData   <= 16'h0000;
            Done     <= 1'b0;
            CE_N     <= 1'b1;
            OE_N     <= 1'b1;
            WE_N     <= 1'b1;
            LB_N     <= 1'b1;
            UB_N     <= 1'b1;
            dq_drive <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            Done     <= done_next;
            CE_N     <= ce_n_next;
            OE_N     <= oe_n_next;
            WE_N     <= we_n_next;
            LB_N     <= lb_n_next;
            UB_N     <= ub_n_next;
            dq_drive <= dq_drive_next;

            if (accept) begin
                lat_data <= WrData;
                lat_be   <= ByteEn;
                ADDR     <= {4'b0000, Addr};
            end

            // Byte lanes that were not enabled float at the SRAM, so they are
            // forced to zero instead of returning whatever is on the bus.
            if (capture) begin
                RdData <= {lat_be[1] ? DQ[15:8] : 8'h00,
                           lat_be[0] ? DQ[7:0]  : 8'h00};
            end
        end
    end

    assign Busy = (state != IDLE);
    assign DQ   = dq_drive ? lat_data : 16'hzzzz;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_access_ctrl
//
// Self-checking bench for sram_access_ctrl. It instantiates two controllers,
// one with WaitStates = 1 (unit 0) and one with WaitStates = 0 (unit 1). Each
// controller is connected to its own behavioural SRAM.
//
// The reference model describes an access as a timeline of cycle offsets from
// the edge where Req was sampled. Every cycle it compares the strobes, Busy,
// Done, ADDR and RdData with that timeline, and it keeps a shadow copy of the
// memory contents.
// ---------------------------------------------------------------------------
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   [2];
    logic        req     [2];
    logic        wr_en   [2];
    logic [15:0] addr    [2];
    logic [15:0] wr_data [2];
    logic [1:0]  byte_en [2];
    logic [15:0] rd_data [2];
    logic        done    [2];
    logic        busy    [2];
    logic        ce_n    [2];
    logic        oe_n    [2];
    logic        we_n    [2];
    logic        lb_n    [2];
    logic        ub_n    [2];
    logic [19:0] sram_addr [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    sram_access_ctrl #(.WaitStates(1)) dut_w1 (
        .Clk(clk), .Reset(reset[0]), .Req(req[0]), .WrEn(wr_en[0]),
        .Addr(addr[0]), .WrData(wr_data[0]), .ByteEn(byte_en[0]),
        .RdData(rd_data[0]), .Done(done[0]), .Busy(busy[0]),
        .CE_N(ce_n[0]), .OE_N(oe_n[0]), .WE_N(we_n[0]),
        .LB_N(lb_n[0]), .UB_N(ub_n[0]), .ADDR(sram_addr[0]), .DQ(dq0)
    );

    sram_access_ctrl #(.WaitStates(0)) dut_w0 (
        .Clk(clk), .Reset(reset[1]), .Req(req[1]), .WrEn(wr_en[1]),
        .Addr(addr[1]), .WrData(wr_data[1]), .ByteEn(byte_en[1]),
        .RdData(rd_data[1]), .Done(done[1]), .Busy(busy[1]),
        .CE_N(ce_n[1]), .OE_N(oe_n[1]), .WE_N(we_n[1]),
        .LB_N(lb_n[1]), .UB_N(ub_n[1]), .ADDR(sram_addr[1]), .DQ(dq1)
    );

    // Initial memory image, shared by the SRAM models and the reference.
    function automatic logic [15:0] init_val(input int a);
        if (a == 32'h20) return 16'h002A;
        if (a == 32'h3C) return 16'hF020;
        return 16'(a * 37) ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] lane_mask(input logic [15:0] v, input logic [1:0] be);
        return {be[1] ? v[15:8] : 8'h00, be[0] ? v[7:0] : 8'h00};
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                              input logic [1:0] be);
        return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
    endfunction

    // Behavioural asynchronous SRAMs, 4K words each. Each one drives the bus
    // while it is selected with OE_N low, and writes the enabled lanes on
    // every clock edge where WE_N is low.
    logic [15:0] mem [2][4096];
    bit          mem_ready = 1'b0;

    assign dq0 = (!ce_n[0] && !oe_n[0]) ? mem[0][sram_addr[0][11:0]] : 16'hzzzz;
    assign dq1 = (!ce_n[1] && !oe_n[1]) ? mem[1][sram_addr[1][11:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int u = 0; u < 2; u++)
                for (int i = 0; i < 4096; i++)
                    mem[u][i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (!ce_n[0] && !we_n[0]) begin
                if (!lb_n[0]) mem[0][sram_addr[0][11:0]][7:0]  <= dq0[7:0];
                if (!ub_n[0]) mem[0][sram_addr[0][11:0]][15:8] <= dq0[15:8];
            end
            if (!ce_n[1] && !we_n[1]) begin
                if (!lb_n[1]) mem[1][sram_addr[1][11:0]][7:0]  <= dq1[7:0];
                if (!ub_n[1]) mem[1][sram_addr[1][11:0]][15:8] <= dq1[15:8];
            end
        end
    end

    // Reference model state
    int          cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;
    bit          mon_en = 1'b0;
    logic [15:0] ref_mem [2][4096];
    bit          tx_active [2];
    int          tx_start  [2];
    bit          tx_wr     [2];
    logic [1:0]  tx_be     [2];
    logic [15:0] tx_addr   [2];
    logic [15:0] tx_data   [2];
    logic [15:0] exp_addr  [2];
    logic [15:0] exp_rd    [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input int u, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL unit%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     u, name, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor, sampled on the falling edge. The offset d counts
    // cycles after the edge that accepted the request.
    //   Read : d = 0..W are access cycles; d = W+1 is the Done cycle.
    //   Write: d = 0 is setup; d = 1..W+1 is the WE pulse; d = W+2 is hold;
    //          d = W+3 is the Done cycle.
    // The expected pins are {CE_N, OE_N, WE_N, LB_N, UB_N, Busy, Done}.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                int         w;
                int         d;
                logic [6:0] s;
                logic       lb;
                logic       ub;
                w  = (u == 0) ? 1 : 0;
                s  = 7'b1111100;
                lb = ~tx_be[u][0];
                ub = ~tx_be[u][1];
                if (tx_active[u]) begin
                    d = cyc - tx_start[u];
                    if (!tx_wr[u]) begin
                        if (d <= w) begin
                            s = {1'b0, 1'b0, 1'b1, lb, ub, 1'b1, 1'b0};
                        end else begin
                            s = 7'b1111101;
                            exp_rd[u] = lane_mask(ref_mem[u][tx_addr[u][11:0]], tx_be[u]);
                            tx_active[u] = 1'b0;
                        end
                    end else begin
                        if (d == 0 || d == w + 2) begin
                            s = {1'b0, 1'b1, 1'b1, lb, ub, 1'b1, 1'b0};
                        end else if (d >= 1 && d <= w + 1) begin
                            s = {1'b0, 1'b1, 1'b0, lb, ub, 1'b1, 1'b0};
                        end else begin
                            s = 7'b1111101;
                            ref_mem[u][tx_addr[u][11:0]] =
                                lane_merge(ref_mem[u][tx_addr[u][11:0]], tx_data[u], tx_be[u]);
                            tx_active[u] = 1'b0;
                        end
                    end
                end
                checkOutput(u, "pins{ce,oe,we,lb,ub,busy,done}",
                            {25'd0, ce_n[u], oe_n[u], we_n[u], lb_n[u], ub_n[u], busy[u], done[u]},
                            {25'd0, s});
                checkOutput(u, "ADDR", {12'd0, sram_addr[u]}, {16'd0, exp_addr[u]});
                checkOutput(u, "RdData", {16'd0, rd_data[u]}, {16'd0, exp_rd[u]});
            end
        end
    end

    // Presents a request, waits for the accepting edge, and records the
    // access in the reference model.
    task automatic startReq(input int u, input bit wr, input logic [15:0] a,
                            input logic [15:0] d, input logic [1:0] be);
        req[u]     = 1'b1;
        wr_en[u]   = wr;
        addr[u]    = a;
        wr_data[u] = d;
        byte_en[u] = be;
        @(posedge clk);
        #1;
        tx_start[u]  = cyc;
        tx_wr[u]     = wr;
        tx_be[u]     = be;
        tx_addr[u]   = a;
        tx_data[u]   = d;
        tx_active[u] = 1'b1;
        exp_addr[u]  = a;
        req[u]       = 1'b0;
    endtask

    // Runs one complete access and returns during its Done cycle, so a
    // request issued right afterwards is a back-to-back request. When noise
    // is set, junk requests are pulsed while the controller is busy; they
    // must all be ignored.
    task automatic applyStimulus(input int u, input bit wr, input logic [15:0] a,
                                 input logic [15:0] d, input logic [1:0] be,
                                 input bit noise, output logic [15:0] got);
        int w;
        bit seen;
        w    = (u == 0) ? 1 : 0;
        seen = 1'b0;
        startReq(u, wr, a, d, be);
        for (int k = 0; k < 16; k++) begin
            if (noise && ($urandom_range(0, 1) == 1)) begin
                req[u]     = 1'b1;
                wr_en[u]   = 1'($urandom_range(0, 1));
                addr[u]    = 16'($urandom);
                wr_data[u] = 16'($urandom);
                byte_en[u] = 2'($urandom_range(0, 3));
            end else begin
                req[u] = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done[u]) begin
                seen = 1'b1;
                break;
            end
        end
        req[u] = 1'b0;
        if (seen) begin
            checkOutput(u, "done_latency", 32'(cyc - tx_start[u]), wr ? 32'(w + 3) : 32'(w + 1));
        end else begin
            n_vec++;
            n_mis++;
            $display("[TB] FAIL unit%0d done_timeout: got no Done expected Done within 16 cycles", u);
        end
        got = rd_data[u];
    endtask

    typedef struct {
        int          unit;
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        tbl [13];
    logic [15:0] got;

    initial begin
        tbl[0]  = '{0, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h002A};
        tbl[1]  = '{0, 1'b1, 16'h0010, 16'h1234, 2'b11, 16'h0000};
        tbl[2]  = '{0, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'h1234};
        tbl[3]  = '{0, 1'b1, 16'h0010, 16'hAB00, 2'b10, 16'h0000};
        tbl[4]  = '{0, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hAB34};
        tbl[5]  = '{0, 1'b1, 16'h0010, 16'h5678, 2'b01, 16'h0000};
        tbl[6]  = '{0, 1'b0, 16'h0010, 16'h0000, 2'b01, 16'h0078};
        tbl[7]  = '{0, 1'b0, 16'h003C, 16'h0000, 2'b10, 16'hF000};
        tbl[8]  = '{0, 1'b0, 16'h003C, 16'h0000, 2'b00, 16'h0000};
        tbl[9]  = '{1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h002A};
        tbl[10] = '{1, 1'b1, 16'h0020, 16'hBEEF, 2'b00, 16'h0000};
        tbl[11] = '{1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h002A};
        tbl[12] = '{0, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hAB78};

        for (int u = 0; u < 2; u++) begin
            reset[u]     = 1'b1;
            req[u]       = 1'b0;
            wr_en[u]     = 1'b0;
            addr[u]      = 16'h0000;
            wr_data[u]   = 16'h0000;
            byte_en[u]   = 2'b00;
            tx_active[u] = 1'b0;
            tx_start[u]  = 0;
            tx_wr[u]     = 1'b0;
            tx_be[u]     = 2'b00;
            tx_addr[u]   = 16'h0000;
            tx_data[u]   = 16'h0000;
            exp_addr[u]  = 16'h0000;
            exp_rd[u]    = 16'h0000;
            for (int i = 0; i < 4096; i++) ref_mem[u][i] = init_val(i);
        end

        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        mon_en   = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, issued back to back
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].unit, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, 1'b0, got);
            if (!tbl[i].wr) checkOutput(tbl[i].unit, $sformatf("tbl%0d_rd", i),
                                        {16'd0, got}, {16'd0, tbl[i].exp_rd});
        end

        // A read requested in the Done cycle of a write is accepted at once
        applyStimulus(0, 1'b1, 16'h0040, 16'h1111, 2'b11, 1'b1, got);
        applyStimulus(0, 1'b0, 16'h003C, 16'h0000, 2'b11, 1'b1, got);
        checkOutput(0, "b2b_rd", {16'd0, got}, 32'h0000F020);

        // Reset during the write pulse abandons the write with no Done
        repeat (2) @(posedge clk);
        #1;
        startReq(0, 1'b1, 16'h0050, 16'h7777, 2'b11);
        @(posedge clk);
        #1;
        reset[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_active[0] = 1'b0;
        exp_addr[0]  = 16'h0000;
        exp_rd[0]    = 16'h0000;
        reset[0]     = 1'b0;
        checkOutput(0, "abort_busy_done", {30'd0, busy[0], done[0]}, 32'd0);
        checkOutput(0, "abort_strobes", {27'd0, ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0]}, 32'h1F);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 16'h0050, 16'h7777, 2'b11, 1'b0, got);
        applyStimulus(0, 1'b0, 16'h0050, 16'h0000, 2'b11, 1'b0, got);
        checkOutput(0, "reissue_rd", {16'd0, got}, 32'h00007777);

        // Randomized traffic on a small address window so that reads often
        // land on earlier writes. The monitor checks every cycle.
        for (int i = 0; i < 150; i++) begin
            int          u;
            bit          wr;
            logic [15:0] a;
            u  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 15));
            applyStimulus(u, wr, a, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1, got);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
